// File: rtl/dq_flow_ctrl.sv
// Decode-queue flow/redirect controller: occupancy tracking, bundle admission,
// stall/flush strobes and the flush -> PC reload -> refill redirect sequence.
module dq_flow_ctrl #(
   parameter int DQ_N      = 8,
   parameter int MQ_N      = 4,
   parameter int FLUSH_CYC = 2,
   parameter int PC_W      = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      fet_valid,
   input  logic [$clog2(MQ_N):0]     fet_cnt,
   output logic                      fet_accept,
   input  logic                      deq_pop,
   input  logic                      redirect_req,
   input  logic [PC_W-1:0]           redirect_pc,
   output logic                      fetch_pc_load,
   output logic [PC_W-1:0]           fetch_pc,
   output logic                      dq_flush,
   output logic                      dq_stall,
   output logic [$clog2(DQ_N):0]     occ,
   output logic                      dq_empty,
   output logic                      dq_full
);

   localparam int CW  = $clog2(MQ_N) + 1;
   localparam int OW  = $clog2(DQ_N) + 1;
   localparam int FCW = $clog2(FLUSH_CYC + 1);

   localparam logic [OW-1:0]  OCC_MAX   = OW'(DQ_N);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(MQ_N);
   localparam logic [FCW-1:0] FLUSH_INI = FCW'(FLUSH_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FLUSH  = 2'd2,
      S_REFILL = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic             fetch_pc_load_q, fetch_pc_load_d;
   logic             dq_flush_q, dq_flush_d;

   logic             active;
   logic             redir;
   logic             pop_eff;
   logic             fits;
   logic [OW:0]      occ_sum;

   assign active  = (state_q == S_RUN) || (state_q == S_REFILL);
   assign redir   = redirect_req && (state_q != S_IDLE);
   assign pop_eff = deq_pop && (occ_q != '0);

   // Admission ignores a same-cycle pop: the freed slot is only credited next cycle.
   assign occ_sum = {1'b0, occ_q} + (OW+1)'(fet_cnt);
   assign fits    = (occ_sum <= {1'b0, OCC_MAX});

   assign fet_accept = fet_valid && (fet_cnt != '0) && active && !redirect_req && fits;

   always_comb begin
      state_d         = state_q;
      occ_d           = occ_q;
      flush_cnt_d     = flush_cnt_q;
      fetch_pc_d      = fetch_pc_q;
      fetch_pc_load_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN, S_REFILL: begin
            occ_d = occ_q - OW'(pop_eff) + (fet_accept ? OW'(fet_cnt) : '0);
            if (state_q == S_REFILL && fet_accept) state_d = S_RUN;
         end
         S_FLUSH: begin
            occ_d = '0;
            if (flush_cnt_q == '0) state_d = S_REFILL;
            else flush_cnt_d = flush_cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A redirect outranks any accept/pop and restarts the flush window.
      if (redir) begin
         state_d         = S_FLUSH;
         flush_cnt_d     = FLUSH_INI;
         occ_d           = '0;
         fetch_pc_d      = redirect_pc;
         fetch_pc_load_d = 1'b1;
      end
   end

   assign dq_flush_d = (state_d == S_IDLE) || (state_d == S_FLUSH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         occ_q           <= '0;
         flush_cnt_q     <= '0;
         fetch_pc_q      <= '0;
         fetch_pc_load_q <= 1'b0;
         dq_flush_q      <= 1'b1;
      end else begin
         state_q         <= state_d;
         occ_q           <= occ_d;
         flush_cnt_q     <= flush_cnt_d;
         fetch_pc_q      <= fetch_pc_d;
         fetch_pc_load_q <= fetch_pc_load_d;
         dq_flush_q      <= dq_flush_d;
      end
   end

   assign dq_stall      = active ? !(deq_pop || fet_accept) : 1'b1;
   assign fetch_pc_load = fetch_pc_load_q;
   assign fetch_pc      = fetch_pc_q;
   assign dq_flush      = dq_flush_q;
   assign occ           = occ_q;
   assign dq_empty      = (occ_q == '0);
   assign dq_full       = (occ_q == OCC_MAX);

   a_cnt_legal: assert property (@(posedge clk) disable iff (rst)
      fet_valid |-> (fet_cnt <= CNT_MAX));
   a_occ_bound: assert property (@(posedge clk) disable iff (rst)
      occ_q <= OCC_MAX);

endmodule

// File: tb/tb_dq_flow_ctrl.sv
// Directed bench for dq_flow_ctrl: reset, admission, full/empty edges,
// single and back-to-back redirects, asynchronous reset mid-run.
module tb_dq_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        fet_valid;
   logic [2:0]  fet_cnt;
   logic        fet_accept;
   logic        deq_pop;
   logic        redirect_req;
   logic [63:0] redirect_pc;
   logic        fetch_pc_load;
   logic [63:0] fetch_pc;
   logic        dq_flush;
   logic        dq_stall;
   logic [3:0]  occ;
   logic        dq_empty;
   logic        dq_full;

   int checks = 0;
   int errors = 0;

   dq_flow_ctrl #(.DQ_N(8), .MQ_N(4), .FLUSH_CYC(2), .PC_W(64)) dut (
      .clk(clk), .rst(rst), .start(start),
      .fet_valid(fet_valid), .fet_cnt(fet_cnt), .fet_accept(fet_accept),
      .deq_pop(deq_pop), .redirect_req(redirect_req), .redirect_pc(redirect_pc),
      .fetch_pc_load(fetch_pc_load), .fetch_pc(fetch_pc),
      .dq_flush(dq_flush), .dq_stall(dq_stall), .occ(occ),
      .dq_empty(dq_empty), .dq_full(dq_full)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the edge; checks happen 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; fet_valid = 1'b0; fet_cnt = '0;
      deq_pop = 1'b0; redirect_req = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; fet_valid = 1'b1; fet_cnt = 3'd2;
      #2;
      checks++; if (occ !== 4'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occ); end
      checks++; if (dq_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", dq_empty); end
      checks++; if (dq_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", dq_full); end
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL rst_flush got %b exp 1", dq_flush); end
      checks++; if (dq_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b exp 1", dq_stall); end
      checks++; if (fet_accept !== 1'b0) begin errors++; $display("FAIL rst_accept got %b exp 0", fet_accept); end
      checks++; if (fetch_pc_load !== 1'b0) begin errors++; $display("FAIL rst_load got %b exp 0", fetch_pc_load); end
      checks++; if (fetch_pc !== 64'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", fetch_pc); end
      fet_valid = 1'b0;
   endtask

   task automatic test_idle_redirect();
      redirect_req = 1'b1; redirect_pc = 64'hdead;
      tick();
      redirect_req = 1'b0;
      #2;
      checks++; if (fetch_pc_load !== 1'b0) begin errors++; $display("FAIL idle_redir_load got %b exp 0", fetch_pc_load); end
      checks++; if (fetch_pc !== 64'h0) begin errors++; $display("FAIL idle_redir_pc got %h exp 0", fetch_pc); end
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL idle_redir_flush got %b exp 1", dq_flush); end
      start = 1'b1;
      tick();
      start = 1'b0;
      #2;
      checks++; if (dq_flush !== 1'b0) begin errors++; $display("FAIL start_flush got %b exp 0", dq_flush); end
      checks++; if (dq_stall !== 1'b1) begin errors++; $display("FAIL run_idle_stall got %b exp 1", dq_stall); end
   endtask

   task automatic test_fill();
      fet_valid = 1'b1; fet_cnt = 3'd0;
      #1;
      checks++; if (fet_accept !== 1'b0) begin errors++; $display("FAIL cnt0_accept got %b exp 0", fet_accept); end
      fet_cnt = 3'd3;
      #1;
      checks++; if (fet_accept !== 1'b1) begin errors++; $display("FAIL fill1_accept got %b exp 1", fet_accept); end
      checks++; if (dq_stall !== 1'b0) begin errors++; $display("FAIL fill1_stall got %b exp 0", dq_stall); end
      tick();
      fet_cnt = 3'd3;
      #2;
      checks++; if (occ !== 4'd3) begin errors++; $display("FAIL fill_occ3 got %0d exp 3", occ); end
      checks++; if (fet_accept !== 1'b1) begin errors++; $display("FAIL fill2_accept got %b exp 1", fet_accept); end
      tick();
      fet_cnt = 3'd2;
      #2;
      checks++; if (occ !== 4'd6) begin errors++; $display("FAIL fill_occ6 got %0d exp 6", occ); end
      checks++; if (fet_accept !== 1'b1) begin errors++; $display("FAIL fill3_accept got %b exp 1", fet_accept); end
      tick();
      fet_cnt = 3'd1;
      #2;
      checks++; if (occ !== 4'd8) begin errors++; $display("FAIL fill_occ8 got %0d exp 8", occ); end
      checks++; if (dq_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", dq_full); end
      checks++; if (fet_accept !== 1'b0) begin errors++; $display("FAIL full_accept got %b exp 0", fet_accept); end
      checks++; if (dq_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", dq_stall); end
      tick();
      #2;
      checks++; if (occ !== 4'd8) begin errors++; $display("FAIL full_hold_occ got %0d exp 8", occ); end
   endtask

   task automatic test_full_pop();
      fet_valid = 1'b1; fet_cnt = 3'd1; deq_pop = 1'b1;
      #2;
      checks++; if (fet_accept !== 1'b0) begin errors++; $display("FAIL fullpop_accept got %b exp 0", fet_accept); end
      checks++; if (dq_stall !== 1'b0) begin errors++; $display("FAIL fullpop_stall got %b exp 0", dq_stall); end
      tick();
      #2;
      checks++; if (occ !== 4'd7) begin errors++; $display("FAIL fullpop_occ got %0d exp 7", occ); end
      checks++; if (fet_accept !== 1'b1) begin errors++; $display("FAIL pop_next_accept got %b exp 1", fet_accept); end
      tick();
      fet_valid = 1'b0; deq_pop = 1'b0;
      #2;
      checks++; if (occ !== 4'd7) begin errors++; $display("FAIL pop_accept_occ got %0d exp 7", occ); end
   endtask

   task automatic test_redirect();
      deq_pop = 1'b1;
      repeat (3) tick();
      deq_pop = 1'b0;
      #2;
      checks++; if (occ !== 4'd4) begin errors++; $display("FAIL pre_redir_occ got %0d exp 4", occ); end
      redirect_req = 1'b1; redirect_pc = 64'h1000; fet_valid = 1'b1; fet_cnt = 3'd1;
      #1;
      checks++; if (fet_accept !== 1'b0) begin errors++; $display("FAIL redir_prio_accept got %b exp 0", fet_accept); end
      tick();
      redirect_req = 1'b0; fet_cnt = 3'd2;
      #2;
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL redir_flush1 got %b exp 1", dq_flush); end
      checks++; if (occ !== 4'd0) begin errors++; $display("FAIL redir_occ got %0d exp 0", occ); end
      checks++; if (fetch_pc_load !== 1'b1) begin errors++; $display("FAIL redir_load got %b exp 1", fetch_pc_load); end
      checks++; if (fetch_pc !== 64'h1000) begin errors++; $display("FAIL redir_pc got %h exp 1000", fetch_pc); end
      checks++; if (dq_stall !== 1'b1) begin errors++; $display("FAIL redir_stall got %b exp 1", dq_stall); end
      checks++; if (fet_accept !== 1'b0) begin errors++; $display("FAIL flush_accept got %b exp 0", fet_accept); end
      tick();
      #2;
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL redir_flush2 got %b exp 1", dq_flush); end
      checks++; if (fetch_pc_load !== 1'b0) begin errors++; $display("FAIL redir_load_once got %b exp 0", fetch_pc_load); end
      checks++; if (fetch_pc !== 64'h1000) begin errors++; $display("FAIL redir_pc_hold got %h exp 1000", fetch_pc); end
      tick();
      #2;
      checks++; if (dq_flush !== 1'b0) begin errors++; $display("FAIL refill_flush got %b exp 0", dq_flush); end
      checks++; if (fet_accept !== 1'b1) begin errors++; $display("FAIL refill_accept got %b exp 1", fet_accept); end
      tick();
      fet_valid = 1'b0;
      #2;
      checks++; if (occ !== 4'd2) begin errors++; $display("FAIL refill_occ got %0d exp 2", occ); end
   endtask

   task automatic test_back_to_back();
      redirect_req = 1'b1; redirect_pc = 64'h1000;
      tick();
      redirect_req = 1'b0;
      #2;
      checks++; if (fetch_pc_load !== 1'b1) begin errors++; $display("FAIL b2b_load1 got %b exp 1", fetch_pc_load); end
      checks++; if (fetch_pc !== 64'h1000) begin errors++; $display("FAIL b2b_pc1 got %h exp 1000", fetch_pc); end
      tick();
      redirect_req = 1'b1; redirect_pc = 64'h2000;
      #2;
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL b2b_flush2 got %b exp 1", dq_flush); end
      tick();
      redirect_req = 1'b0;
      #2;
      checks++; if (fetch_pc_load !== 1'b1) begin errors++; $display("FAIL b2b_load2 got %b exp 1", fetch_pc_load); end
      checks++; if (fetch_pc !== 64'h2000) begin errors++; $display("FAIL b2b_pc2 got %h exp 2000", fetch_pc); end
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL b2b_restart1 got %b exp 1", dq_flush); end
      tick();
      #2;
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL b2b_restart2 got %b exp 1", dq_flush); end
      checks++; if (fetch_pc_load !== 1'b0) begin errors++; $display("FAIL b2b_load_drop got %b exp 0", fetch_pc_load); end
      tick();
      #2;
      checks++; if (dq_flush !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", dq_flush); end
   endtask

   task automatic test_empty_pop();
      deq_pop = 1'b1; fet_valid = 1'b0;
      #2;
      checks++; if (dq_stall !== 1'b0) begin errors++; $display("FAIL empty_pop_stall got %b exp 0", dq_stall); end
      tick();
      deq_pop = 1'b0;
      #2;
      checks++; if (occ !== 4'd0) begin errors++; $display("FAIL empty_pop_occ got %0d exp 0", occ); end
      checks++; if (dq_empty !== 1'b1) begin errors++; $display("FAIL empty_pop_empty got %b exp 1", dq_empty); end
   endtask

   task automatic test_rst_mid_run();
      fet_valid = 1'b1; fet_cnt = 3'd3;
      tick();
      fet_cnt = 3'd2;
      tick();
      fet_cnt = 3'd1;
      #2;
      checks++; if (occ !== 4'd5) begin errors++; $display("FAIL pre_rst_occ got %0d exp 5", occ); end
      rst = 1'b1;
      #1;
      checks++; if (occ !== 4'd0) begin errors++; $display("FAIL async_rst_occ got %0d exp 0", occ); end
      checks++; if (dq_flush !== 1'b1) begin errors++; $display("FAIL async_rst_flush got %b exp 1", dq_flush); end
      checks++; if (dq_stall !== 1'b1) begin errors++; $display("FAIL async_rst_stall got %b exp 1", dq_stall); end
      checks++; if (fet_accept !== 1'b0) begin errors++; $display("FAIL async_rst_accept got %b exp 0", fet_accept); end
      tick();
      rst = 1'b0; fet_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      #2;
      checks++; if (dq_flush !== 1'b0) begin errors++; $display("FAIL restart_flush got %b exp 0", dq_flush); end
      checks++; if (occ !== 4'd0) begin errors++; $display("FAIL restart_occ got %0d exp 0", occ); end
   endtask

   initial begin
      test_reset();
      test_idle_redirect();
      tick();
      test_fill();
      tick();
      test_full_pop();
      tick();
      test_redirect();
      tick();
      test_back_to_back();
      tick();
      test_empty_pop();
      tick();
      test_rst_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
